// File: rtl/ea_mem_unit.sv
// LC-3 effective-address adder and LEA/LD/LDI/ST/STI memory sequencer.
// Every output is a flop, so strobes and status change only on clock edges or reset.
module ea_mem_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        addr1_sel,
  input  logic [15:0] pc,
  input  logic [15:0] base_r,
  input  logic [15:0] addr2_off,
  input  logic [15:0] st_data,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] ea,
  output logic [15:0] ld_data,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_RD1,
    S_RD2,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_LEA = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_ST  = 3'b011;
  localparam logic [2:0] OP_STI = 3'b100;

  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);
  localparam bit         TMO_EN    = (MEM_TIMEOUT != 0);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] base_q, base_d;
  logic [15:0] off_q, off_d;
  logic [15:0] sdata_q, sdata_d;
  logic [15:0] ea_q, ea_d;
  logic [15:0] ld_q, ld_d;
  logic        err_q, err_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [15:0] sum;
  logic [7:0]  cnt_inc;
  logic        waiting;
  logic        tmo_hit;

  assign sum     = base_q + off_q;
  assign cnt_inc = cnt_q + 8'd1;
  // A cycle only counts toward the timeout while a strobe is actually out.
  assign waiting = (rd_q | wr_q) & ~mem_ready;
  assign tmo_hit = TMO_EN && waiting && (cnt_inc == TMO_LIMIT);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    off_d   = off_q;
    sdata_d = sdata_q;
    ea_d    = ea_q;
    ld_d    = ld_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          op_d    = op;
          base_d  = addr1_sel ? base_r : pc;
          off_d   = addr2_off;
          sdata_d = st_data;
          err_d   = 1'b0;
        end
      end

      S_CALC: begin
        ea_d  = sum;
        cnt_d = 8'd0;
        case (op_q)
          OP_LEA: state_d = S_DONE;
          OP_LD, OP_LDI, OP_STI: begin
            addr_d  = sum;
            rd_d    = 1'b1;
            state_d = S_RD1;
          end
          OP_ST: begin
            addr_d  = sum;
            wdata_d = sdata_q;
            wr_d    = 1'b1;
            state_d = S_WR;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end

      S_RD1: begin
        if (rd_q && mem_ready) begin
          rd_d  = 1'b0;
          cnt_d = 8'd0;
          case (op_q)
            OP_LD: begin
              ld_d    = mem_rdata;
              state_d = S_DONE;
            end
            OP_LDI: begin
              addr_d  = mem_rdata;
              state_d = S_RD2;
            end
            default: begin
              addr_d  = mem_rdata;
              wdata_d = sdata_q;
              state_d = S_WR;
            end
          endcase
        end else if (tmo_hit) begin
          rd_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (waiting) begin
          cnt_d = cnt_inc;
        end
      end

      S_RD2: begin
        // Entered with the strobe low; the first cycle here is the gap cycle.
        if (!rd_q) begin
          rd_d = 1'b1;
        end else if (mem_ready) begin
          rd_d    = 1'b0;
          ld_d    = mem_rdata;
          state_d = S_DONE;
        end else if (tmo_hit) begin
          rd_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WR: begin
        if (!wr_q) begin
          wr_d = 1'b1;
        end else if (mem_ready) begin
          wr_d    = 1'b0;
          state_d = S_DONE;
        end else if (tmo_hit) begin
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_RD1) ||
             (state_d == S_RD2)  || (state_d == S_WR);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      base_q  <= 16'd0;
      off_q   <= 16'd0;
      sdata_q <= 16'd0;
      ea_q    <= 16'd0;
      ld_q    <= 16'd0;
      err_q   <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      off_q   <= off_d;
      sdata_q <= sdata_d;
      ea_q    <= ea_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ea        = ea_q;
  assign ld_data   = ld_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ea_mem_unit.sv
// Directed bench for ea_mem_unit: wait-state memory model plus an expectation queue
// popped each time an operation reports done.
module tb_ea_mem_unit;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        addr1_sel = 1'b0;
  logic [15:0] pc = 16'd0;
  logic [15:0] base_r = 16'd0;
  logic [15:0] addr2_off = 16'd0;
  logic [15:0] st_data = 16'd0;
  logic [15:0] mem_rdata = 16'd0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_addr, mem_wdata, ea, ld_data;
  logic        mem_rd, mem_wr, busy, done, err;

  ea_mem_unit #(.MEM_TIMEOUT(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .op(op), .addr1_sel(addr1_sel),
    .pc(pc), .base_r(base_r), .addr2_off(addr2_off), .st_data(st_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .ea(ea), .ld_data(ld_data), .err(err)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Memory model: answers each strobe after 'waits' low-ready cycles, unless stuck.
  logic [15:0] mem [0:65535];
  int          waits = 0;
  bit          stuck = 1'b0;
  int          wcnt = 0;

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (Reset_n && (mem_rd || mem_wr) && !stuck) begin
        if (wcnt < waits) begin
          wcnt++;
          mem_ready = 1'b0;
        end else begin
          wcnt = 0;
          mem_ready = 1'b1;
          if (mem_rd) mem_rdata = mem[mem_addr];
          else mem[mem_addr] = mem_wdata;
        end
      end else begin
        wcnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  typedef struct {
    string       name;
    logic [15:0] ea;
    logic [15:0] ld;
    logic        err;
    int          lat;   // 0: latency not checked
    int          nrd;
    int          nwr;
  } exp_t;
  exp_t sb[$];

  int          got_lat, got_nrd, got_nwr, got_rdcyc, got_overlap;
  logic [15:0] ra0, ra1, wa0, wd0;
  logic        busy_c1;

  task automatic push(input string n, input logic [15:0] e, input logic [15:0] l,
                      input logic er, input int lat, input int nrd, input int nwr);
    exp_t x;
    x.name = n; x.ea = e; x.ld = l; x.err = er; x.lat = lat; x.nrd = nrd; x.nwr = nwr;
    sb.push_back(x);
  endtask

  task automatic run_op(input logic [2:0] o, input logic sel, input logic [15:0] p,
                        input logic [15:0] b, input logic [15:0] off,
                        input logic [15:0] sd, input bit hold);
    bit   seen = 1'b0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    exp_t e;
    got_lat = 0; got_nrd = 0; got_nwr = 0; got_rdcyc = 0; got_overlap = 0;
    ra0 = 16'hxxxx; ra1 = 16'hxxxx; wa0 = 16'hxxxx; wd0 = 16'hxxxx; busy_c1 = 1'b0;
    @(negedge Clk);
    op = o; addr1_sel = sel; pc = p; base_r = b; addr2_off = off; st_data = sd;
    start = 1'b1;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        busy_c1 = busy;
        if (!hold) start = 1'b0;
        op = 3'd7; pc = 16'hDEAD; base_r = 16'hDEAD; addr2_off = 16'hDEAD; st_data = 16'hDEAD;
      end
      if (mem_rd && mem_wr) got_overlap++;
      if (mem_rd) got_rdcyc++;
      if (mem_rd && !prev_rd) begin
        if (got_nrd == 0) ra0 = mem_addr; else ra1 = mem_addr;
        got_nrd++;
      end
      if (mem_wr && !prev_wr) begin
        wa0 = mem_addr; wd0 = mem_wdata;
        got_nwr++;
      end
      prev_rd = mem_rd; prev_wr = mem_wr;
      if (done) begin
        seen = 1'b1;
        got_lat = c;
        start = 1'b0;
      end
    end
    e = sb.pop_front();
    chk({e.name, "_done_seen"}, 64'(seen), 64'd1);
    chk({e.name, "_busy"}, 64'(busy_c1), 64'd1);
    if (e.lat != 0) chk({e.name, "_latency"}, 64'(got_lat), 64'(e.lat));
    chk({e.name, "_ea"}, 64'(ea), 64'(e.ea));
    chk({e.name, "_ld_data"}, 64'(ld_data), 64'(e.ld));
    chk({e.name, "_err"}, 64'(err), 64'(e.err));
    chk({e.name, "_rd_bursts"}, 64'(got_nrd), 64'(e.nrd));
    chk({e.name, "_wr_bursts"}, 64'(got_nwr), 64'(e.nwr));
    chk({e.name, "_overlap"}, 64'(got_overlap), 64'd0);
    @(negedge Clk);
    chk({e.name, "_idle_after"}, 64'({busy, done}), 64'd0);
    $display("op %s: ea=%h ld_data=%h err=%0d latency=%0d rd=%0d wr=%0d",
             e.name, ea, ld_data, err, got_lat, got_nrd, got_nwr);
  endtask

  initial begin
    int  rises;
    bit  hit;
    logic prev;
    int  extra_done;

    #12;
    chk("reset_data", {mem_addr, mem_wdata, ea, ld_data}, 64'd0);
    chk("reset_ctrl", 64'({mem_rd, mem_wr, busy, done, err}), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    push("LEA", 16'h2FFE, 16'h0000, 1'b0, 2, 0, 0);
    run_op(3'b000, 1'b0, 16'h3000, 16'h1111, 16'hFFFE, 16'h0, 1'b0);

    waits = 2; mem[16'h4005] = 16'hBEEF;
    push("LD_wait2", 16'h4005, 16'hBEEF, 1'b0, 5, 1, 0);
    run_op(3'b001, 1'b1, 16'h0000, 16'h4000, 16'h0005, 16'h0, 1'b0);
    chk("LD_wait2_rd_cycles", 64'(got_rdcyc), 64'd3);
    chk("LD_wait2_addr", 64'(ra0), 64'h4005);

    waits = 0; mem[16'h3011] = 16'h5000; mem[16'h5000] = 16'h1234;
    push("LDI", 16'h3011, 16'h1234, 1'b0, 0, 2, 0);
    run_op(3'b010, 1'b0, 16'h3001, 16'h0000, 16'h0010, 16'h0, 1'b0);
    chk("LDI_addr1", 64'(ra0), 64'h3011);
    chk("LDI_addr2", 64'(ra1), 64'h5000);

    mem[16'h3002] = 16'h6000; mem[16'h6000] = 16'h0000;
    push("STI", 16'h3002, 16'h1234, 1'b0, 0, 1, 1);
    run_op(3'b100, 1'b0, 16'h3000, 16'h0000, 16'h0002, 16'hA5A5, 1'b0);
    chk("STI_raddr", 64'(ra0), 64'h3002);
    chk("STI_waddr", 64'(wa0), 64'h6000);
    chk("STI_wdata", 64'(wd0), 64'hA5A5);
    chk("STI_mem", 64'(mem[16'h6000]), 64'hA5A5);

    push("ST", 16'h4000, 16'h1234, 1'b0, 3, 0, 1);
    run_op(3'b011, 1'b0, 16'h3100, 16'h0000, 16'h0F00, 16'h1357, 1'b0);
    chk("ST_waddr", 64'(wa0), 64'h4000);
    chk("ST_wdata", 64'(wd0), 64'h1357);

    stuck = 1'b1;
    push("LD_timeout", 16'h3020, 16'h1234, 1'b1, 6, 1, 0);
    run_op(3'b001, 1'b0, 16'h3000, 16'h0000, 16'h0020, 16'h0, 1'b0);
    chk("LD_timeout_rd_cycles", 64'(got_rdcyc), 64'd4);
    stuck = 1'b0;

    push("LEA_clr_err", 16'h1001, 16'h1234, 1'b0, 2, 0, 0);
    run_op(3'b000, 1'b0, 16'h1000, 16'h0000, 16'h0001, 16'h0, 1'b0);

    push("ILLEGAL", 16'h3333, 16'h1234, 1'b1, 2, 0, 0);
    run_op(3'b110, 1'b0, 16'h2222, 16'h0000, 16'h1111, 16'h0, 1'b0);

    // Reset asserted while the second LDI read is outstanding.
    waits = 2; rises = 0; hit = 1'b0; prev = 1'b0;
    @(negedge Clk);
    op = 3'b010; addr1_sel = 1'b0; pc = 16'h3001; addr2_off = 16'h0010; start = 1'b1;
    for (int c = 1; c <= 40 && !hit; c++) begin
      @(negedge Clk);
      start = 1'b0;
      if (mem_rd && !prev) rises++;
      prev = mem_rd;
      if (rises == 2) hit = 1'b1;
    end
    chk("rst_reached_rd2", 64'(hit), 64'd1);
    Reset_n = 1'b0;
    #1;
    chk("rst_mid_data", {mem_addr, mem_wdata, ea, ld_data}, 64'd0);
    chk("rst_mid_ctrl", 64'({mem_rd, mem_wr, busy, done, err}), 64'd0);
    $display("op RST_MID_RD2: mem_rd=%0d busy=%0d ea=%h", mem_rd, busy, ea);
    @(negedge Clk);
    Reset_n = 1'b1;
    waits = 0;
    extra_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      if (done || busy || mem_rd) extra_done++;
    end
    chk("rst_nothing_completes", 64'(extra_done), 64'd0);

    mem[16'h0001] = 16'h7777;
    push("LD_wrap_hold", 16'h0001, 16'h7777, 1'b0, 3, 1, 0);
    run_op(3'b001, 1'b1, 16'h0000, 16'hFFFF, 16'h0002, 16'h0, 1'b1);
    extra_done = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      if (done || busy) extra_done++;
    end
    chk("hold_no_second_op", 64'(extra_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
